axi_sram_slave: RTL and testbench

//  AXI3 slave that models main memory for the CPU-side bridge master. It serves

---
 rtl/axi_sram_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI3 memory slave: a word array served by independent read and write burst FSMs,
// with a programmable gap between AR acceptance and the first read beat.
module axi_sram_slave #(
  parameter int    DEPTH     = 1024,
  parameter int    RD_DELAY  = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IW       = $clog2(DEPTH);
  localparam logic [31:0] BYTES    = 32'(DEPTH * 4);
  localparam logic [3:0]  DLY      = 4'(RD_DELAY);
  localparam bit          NO_DELAY = (RD_DELAY == 0);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  logic [31:0] r_mem [DEPTH];

  logic        r_en;
  rd_state_t   r_rdState, w_rdNext;
  logic [3:0]  r_arId, r_rdLen, r_rdBeat, r_rdDelay;
  logic [1:0]  r_rdSize;
  logic        r_rdFixed;
  logic [31:0] r_rdAddr, r_rdata;
  logic [1:0]  r_rresp;
  logic        w_arHs, w_rHs, w_rdLast, w_rdLoad;
  logic [31:0] w_rdLoadAddr;
  logic [1:0]  w_arSize, w_awSize;

  wr_state_t   r_wrState, w_wrNext;
  logic [3:0]  r_awId, r_wrLen, r_wrBeat;
  logic [1:0]  r_wrSize;
  logic        r_wrFixed, r_wErr;
  logic [31:0] r_wrAddr;
  logic        w_awHs, w_wHs, w_bHs, w_wrLast, w_wrInRange;

  logic w_unused;
  assign w_unused = ^{arlen[7:4], awlen[7:4], arlock, arcache, arprot,
                      awlock, awcache, awprot, wid};

  // Sizes above one word behave as full-word beats.
  assign w_arSize = (arsize > 3'd2) ? 2'd2 : arsize[1:0];
  assign w_awSize = (awsize > 3'd2) ? 2'd2 : awsize[1:0];

  assign arready  = r_en & (r_rdState == R_IDLE);
  assign rvalid   = (r_rdState == R_DATA);
  assign w_arHs   = arvalid & arready;
  assign w_rHs    = rvalid & rready;
  assign w_rdLast = (r_rdBeat == r_rdLen);
  assign rlast    = rvalid & w_rdLast;
  assign rid      = r_arId;
  assign rdata    = r_rdata;
  assign rresp    = r_rresp;

  always_comb begin
    w_rdNext     = r_rdState;
    w_rdLoad     = 1'b0;
    w_rdLoadAddr = r_rdAddr;
    case (r_rdState)
      R_IDLE: if (w_arHs) begin
        w_rdLoadAddr = araddr;
        if (NO_DELAY) begin
          w_rdNext = R_DATA;
          w_rdLoad = 1'b1;
        end else begin
          w_rdNext = R_WAIT;
        end
      end
      R_WAIT: if (r_rdDelay == 4'd0) begin
        w_rdNext = R_DATA;
        w_rdLoad = 1'b1;
      end
      R_DATA: if (w_rHs) begin
        if (w_rdLast) begin
          w_rdNext = R_IDLE;
        end else begin
          w_rdLoad     = 1'b1;
          w_rdLoadAddr = r_rdFixed ? r_rdAddr : r_rdAddr + (32'd1 << r_rdSize);
        end
      end
      default: w_rdNext = R_IDLE;
    endcase
  end

  // rdata is fetched one beat ahead so it is already registered when rvalid rises.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_en      <= 1'b0;
      r_rdState <= R_IDLE;
      r_arId    <= '0;
      r_rdLen   <= '0;
      r_rdBeat  <= '0;
      r_rdDelay <= '0;
      r_rdSize  <= '0;
      r_rdFixed <= 1'b0;
      r_rdAddr  <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
    end else begin
      r_en      <= 1'b1;
      r_rdState <= w_rdNext;
      if (w_arHs) begin
        r_arId    <= arid;
        r_rdLen   <= arlen[3:0];
        r_rdSize  <= w_arSize;
        r_rdFixed <= (arburst == 2'b00);
        r_rdBeat  <= '0;
        r_rdDelay <= DLY;
      end else if (r_rdState == R_WAIT && r_rdDelay != 4'd0) begin
        r_rdDelay <= r_rdDelay - 4'd1;
      end
      if (w_rdLoad) begin
        r_rdAddr <= w_rdLoadAddr;
        if (w_rdLoadAddr < BYTES) begin
          r_rdata <= r_mem[w_rdLoadAddr[IW+1:2]];
          r_rresp <= 2'b00;
        end else begin
          r_rdata <= '0;
          r_rresp <= 2'b10;
        end
      end else if (w_arHs) begin
        r_rdAddr <= araddr;
      end
      if (w_rHs && !w_rdLast) r_rdBeat <= r_rdBeat + 4'd1;
    end
  end

  assign awready     = r_en & (r_wrState == W_IDLE);
  assign wready      = (r_wrState == W_DATA);
  assign bvalid      = (r_wrState == W_RESP);
  assign bid         = r_awId;
  assign bresp       = r_wErr ? 2'b10 : 2'b00;
  assign w_awHs      = awvalid & awready;
  assign w_wHs       = wvalid & wready;
  assign w_bHs       = bvalid & bready;
  assign w_wrLast    = (r_wrBeat == r_wrLen);
  assign w_wrInRange = (r_wrAddr < BYTES);

  always_comb begin
    w_wrNext = r_wrState;
    case (r_wrState)
      W_IDLE:  if (w_awHs) w_wrNext = W_DATA;
      W_DATA:  if (w_wHs && w_wrLast) w_wrNext = W_RESP;
      W_RESP:  if (w_bHs) w_wrNext = W_IDLE;
      default: w_wrNext = W_IDLE;
    endcase
  end

  // The beat counter, not wlast, ends the burst; a wlast mismatch only flags SLVERR.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wrState <= W_IDLE;
      r_awId    <= '0;
      r_wrLen   <= '0;
      r_wrBeat  <= '0;
      r_wrSize  <= '0;
      r_wrFixed <= 1'b0;
      r_wrAddr  <= '0;
      r_wErr    <= 1'b0;
    end else begin
      r_wrState <= w_wrNext;
      if (w_awHs) begin
        r_awId    <= awid;
        r_wrAddr  <= awaddr;
        r_wrLen   <= awlen[3:0];
        r_wrSize  <= w_awSize;
        r_wrFixed <= (awburst == 2'b00);
        r_wrBeat  <= '0;
        r_wErr    <= 1'b0;
      end else if (w_wHs) begin
        r_wrBeat <= r_wrBeat + 4'd1;
        if (!r_wrFixed) r_wrAddr <= r_wrAddr + (32'd1 << r_wrSize);
        if (!w_wrInRange || (wlast != w_wrLast)) r_wErr <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_wHs && w_wrInRange) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) r_mem[r_wrAddr[IW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed scenarios plus randomized bursts,
// all compared against a plain word-array memory model.
module tb_axi_sram_slave;

  localparam int DEPTH    = 1024;
  localparam int RD_DELAY = 2;
  localparam int BYTES    = DEPTH * 4;

  logic        aclk, aresetn;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int nTests = 0;
  int nFail  = 0;

  logic [31:0] refMem  [DEPTH];
  logic [31:0] expData [16];
  logic [1:0]  expResp [16];

  axi_sram_slave #(.DEPTH(DEPTH), .RD_DELAY(RD_DELAY), .INIT_FILE("")) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address of the following beat: FIXED holds, everything else advances by the beat size.
  function automatic logic [31:0] modelNext(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    int sz;
    sz = (size > 3'd2) ? 2 : int'(size);
    return (burst == 2'b00) ? a : a + (32'd1 << sz);
  endfunction

  task automatic computeReadExpect(input logic [31:0] addr, input int len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    a = addr;
    for (int b = 0; b <= len; b++) begin
      if (a < BYTES) begin
        expData[b] = refMem[a[11:2]];
        expResp[b] = 2'b00;
      end else begin
        expData[b] = 32'h0;
        expResp[b] = 2'b10;
      end
      a = modelNext(a, size, burst);
    end
  endtask

  task automatic addrAR(input logic [3:0] id, input logic [31:0] addr, input int len,
                        input logic [2:0] size, input logic [1:0] burst);
    int cyc;
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst;
    arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 64) begin
      @(negedge aclk);
      cyc++;
    end
    checkOutput("arready_wait", 32'(arready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  task automatic addrAW(input logic [3:0] id, input logic [31:0] addr, input int len,
                        input logic [2:0] size, input logic [1:0] burst);
    int cyc;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
    awvalid = 1'b1;
    cyc = 0;
    while (!awready && cyc < 64) begin
      @(negedge aclk);
      cyc++;
    end
    checkOutput("awready_wait", 32'(awready), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic readAR(input logic [3:0] id, input logic [31:0] addr, input int len,
                        input logic [2:0] size, input logic [1:0] burst);
    int cyc;
    addrAR(id, addr, len, size, burst);
    cyc = 0;
    while (!rvalid && cyc < 64) begin
      @(negedge aclk);
      cyc++;
    end
    checkOutput("rd_latency", 32'(cyc), 32'(RD_DELAY + 1));
  endtask

  // mode 0: rready always high, 1: alternating starting high, 2: random with bounded stalls
  task automatic readBeats(input logic [3:0] id, input int len, input int mode);
    int beat, cyc, stalls;
    bit tg;
    beat = 0; stalls = 0; tg = 1'b1;
    while (beat <= len) begin
      cyc = 0;
      while (!rvalid && cyc < 64) begin
        rready = 1'b0;
        @(negedge aclk);
        cyc++;
      end
      checkOutput("rvalid", 32'(rvalid), 32'd1);
      if (!rvalid) break;
      checkOutput("rid", 32'(rid), 32'(id));
      checkOutput("rdata", rdata, expData[beat]);
      checkOutput("rresp", 32'(rresp), 32'(expResp[beat]));
      checkOutput("rlast", 32'(rlast), 32'(beat == len));
      case (mode)
        0:       rready = 1'b1;
        1:       rready = tg;
        default: rready = ($urandom_range(0, 1) == 1) || (stalls >= 3);
      endcase
      tg = ~tg;
      if (rready) begin
        beat++;
        stalls = 0;
      end else begin
        stalls++;
      end
      @(negedge aclk);
    end
    rready = 1'b0;
    checkOutput("rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
    computeReadExpect(addr, len, size, burst);
    readAR(id, addr, len, size, burst);
    readBeats(id, len, mode);
  endtask

  task automatic waitB(input logic [3:0] id, input logic [1:0] resp);
    int cyc;
    bready = 1'b1;
    cyc = 0;
    while (!bvalid && cyc < 64) begin
      @(negedge aclk);
      cyc++;
    end
    checkOutput("bvalid", 32'(bvalid), 32'd1);
    checkOutput("bid", 32'(bid), 32'(id));
    checkOutput("bresp", 32'(bresp), 32'(resp));
    @(negedge aclk);
    bready = 1'b0;
    checkOutput("bvalid_drop", 32'(bvalid), 32'd0);
  endtask

  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input int wlastPos, input logic [31:0] data0,
                               input logic [3:0] strb0, input bit randStrb);
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          err;
    int          cyc;
    a = addr; err = 1'b0;
    addrAW(id, addr, len, size, burst);
    for (int b = 0; b <= len; b++) begin
      d = (b == 0) ? data0 : $urandom;
      s = randStrb ? 4'($urandom_range(0, 15)) : strb0;
      wid = id; wdata = d; wstrb = s; wlast = (b == wlastPos); wvalid = 1'b1;
      cyc = 0;
      while (!wready && cyc < 64) begin
        @(negedge aclk);
        cyc++;
      end
      checkOutput("wready_wait", 32'(wready), 32'd1);
      @(negedge aclk);
      if (a < BYTES) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) refMem[a[11:2]][8*i +: 8] = d[8*i +: 8];
      end else begin
        err = 1'b1;
      end
      if ((b == wlastPos) != (b == len)) err = 1'b1;
      a = modelNext(a, size, burst);
    end
    wvalid = 1'b0; wlast = 1'b0;
    waitB(id, err ? 2'b10 : 2'b00);
  endtask

  initial begin
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    arlock = '0; arcache = '0; arprot = '0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    awlock = '0; awcache = '0; awprot = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    #1;
    checkOutput("rst_arready", 32'(arready), 32'd0);
    checkOutput("rst_awready", 32'(awready), 32'd0);
    checkOutput("rst_wready", 32'(wready), 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_rlast", 32'(rlast), 32'd0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    #1 checkOutput("release_arready", 32'(arready), 32'd0);
    @(negedge aclk);
    checkOutput("enabled_arready", 32'(arready), 32'd1);
    checkOutput("enabled_awready", 32'(awready), 32'd1);
    checkOutput("idle_wready", 32'(wready), 32'd0);

    for (int i = 0; i < DEPTH / 16; i++)
      applyStimulus(4'(i), 32'(i * 64), 15, 3'd2, 2'b01, 15, $urandom, 4'hF, 1'b0);

    applyStimulus(4'd1, 32'h10, 0, 3'd2, 2'b01, 0, 32'h12345678, 4'hF, 1'b0);
    readBurst(4'd1, 32'h10, 0, 3'd2, 2'b01, 0);

    readBurst(4'd2, 32'h20, 3, 3'd2, 2'b01, 1);

    applyStimulus(4'd1, 32'h30, 0, 3'd2, 2'b01, 0, 32'h11111111, 4'hF, 1'b0);
    applyStimulus(4'd1, 32'h30, 0, 3'd2, 2'b01, 0, 32'hAABBCCDD, 4'b0101, 1'b0);
    readBurst(4'd4, 32'h30, 0, 3'd2, 2'b01, 0);

    readBurst(4'd6, 32'(BYTES), 0, 3'd2, 2'b01, 0);
    applyStimulus(4'd7, 32'h200, 1, 3'd2, 2'b01, 0, $urandom, 4'hF, 1'b0);
    applyStimulus(4'd8, 32'(BYTES - 4), 1, 3'd2, 2'b01, 1, $urandom, 4'hF, 1'b0);
    readBurst(4'd9, 32'(BYTES - 8), 3, 3'd2, 2'b01, 2);
    readBurst(4'd10, 32'h50, 3, 3'd5, 2'b00, 0);
    readBurst(4'd11, 32'h60, 3, 3'd7, 2'b10, 2);
    readBurst(4'd12, 32'h71, 7, 3'd0, 2'b01, 0);

    // Write commit lands on the same edge that loads rdata for the same word.
    computeReadExpect(32'h40, 0, 3'd2, 2'b01);
    addrAW(4'd2, 32'h40, 0, 3'd2, 2'b01);
    addrAR(4'd3, 32'h40, 0, 3'd2, 2'b01);
    @(negedge aclk);
    @(negedge aclk);
    wid = 4'd2; wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    checkOutput("collide_wready", 32'(wready), 32'd1);
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
    refMem[32'h40 >> 2] = 32'hCAFEF00D;
    readBeats(4'd3, 0, 0);
    waitB(4'd2, 2'b00);
    readBurst(4'd3, 32'h40, 0, 3'd2, 2'b01, 0);

    computeReadExpect(32'h100, 3, 3'd2, 2'b01);
    readAR(4'd5, 32'h100, 3, 3'd2, 2'b01);
    rready = 1'b1;
    checkOutput("rstburst_beat0", rdata, expData[0]);
    @(negedge aclk);
    checkOutput("rstburst_beat1", rdata, expData[1]);
    @(negedge aclk);
    checkOutput("rstburst_beat2", rdata, expData[2]);
    aresetn = 1'b0;
    #1;
    checkOutput("midrst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("midrst_arready", 32'(arready), 32'd0);
    checkOutput("midrst_rdata", rdata, 32'd0);
    rready = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1 checkOutput("rerelease_arready", 32'(arready), 32'd0);
    @(posedge aclk);
    #1 checkOutput("reenabled_arready", 32'(arready), 32'd1);
    @(negedge aclk);
    readBurst(4'd5, 32'h100, 3, 3'd2, 2'b01, 0);

    for (int n = 0; n < 30; n++) begin
      int len, wlp;
      logic [31:0] a;
      len = $urandom_range(0, 15);
      wlp = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : len;
      a   = $urandom_range(0, BYTES - 1);
      applyStimulus(4'($urandom_range(0, 15)), a, len, 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 2)), wlp, $urandom, 4'hF, 1'b1);
      a   = $urandom_range(0, BYTES - 1);
      readBurst(4'($urandom_range(0, 15)), a, $urandom_range(0, 15),
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), 2);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
